// File: rtl/fp_accum_pkg.sv
// Shared FP32 constants, FSM state type and an operand-loading helper for
// the fp_accum block and its combinational adder.
package fp_accum_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int BIAS       = 127;
  // Biased exponent value reserved for Inf/NaN.
  localparam int EXP_MAX    = 2 * BIAS + 1;

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // First element of a vector: denormals flush to signed zero, NaNs
  // become the canonical quiet NaN, everything else passes through.
  function automatic logic [31:0] fp_load(input logic [31:0] x);
    logic [31:0] r;
    r = x;
    if (x[30:23] == 8'h00) begin
      r = {x[31], 31'b0};
    end else if ((x[30:23] == 8'hFF) && (x[22:0] != 23'b0)) begin
      r = QNAN;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_add_comb.sv
// Single-cycle combinational FP32 adder: flush-to-zero, RNE rounding over
// the aligned significand with guard/round/sticky, canonical NaN.
module fp_add_comb
  import fp_accum_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  // hidden bit + mantissa + guard, round, sticky
  localparam int SW = MANT_WIDTH + 4;
  localparam logic signed [9:0] EXP_LIM = 10'(EXP_MAX);

  logic                 sa, sb, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_WIDTH-1:0] ea, eb, e_big, e_sml, e_diff;
  logic [MANT_WIDTH-1:0] ma, mb, m_big, m_sml;
  logic                 s_big, eff_sub, rnd_up;
  logic [4:0]           sh, lz;
  logic [SW-1:0]        sig_big, sig_sml, sig_aln, norm;
  logic [2*SW-1:0]      aln_wide;
  logic [SW:0]          raw;
  logic signed [9:0]    e_norm, e_fin;
  logic [24:0]          mant_rnd;
  logic [31:0]          finite_sum;

  // Align, add/subtract, normalise and round the two normal operands.
  always_comb begin
    sa = a[31]; ea = a[30:23]; ma = a[22:0];
    sb = b[31]; eb = b[30:23]; mb = b[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_nan  = (ea == 8'hFF) && (ma != 23'b0);
    b_nan  = (eb == 8'hFF) && (mb != 23'b0);
    a_inf  = (ea == 8'hFF) && (ma == 23'b0);
    b_inf  = (eb == 8'hFF) && (mb == 23'b0);

    // Larger magnitude operand goes on the "big" side.
    if ({ea, ma} < {eb, mb}) begin
      s_big = sb; e_big = eb; m_big = mb; e_sml = ea; m_sml = ma;
    end else begin
      s_big = sa; e_big = ea; m_big = ma; e_sml = eb; m_sml = mb;
    end
    eff_sub = (sa != sb);

    sig_big = {1'b1, m_big, 3'b000};
    sig_sml = {1'b1, m_sml, 3'b000};
    e_diff  = e_big - e_sml;
    sh      = (e_diff > 8'd27) ? 5'd27 : e_diff[4:0];
    // Bits shifted below the sticky position are OR-ed into it.
    aln_wide = {sig_sml, {SW{1'b0}}} >> sh;
    sig_aln  = aln_wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |aln_wide[SW-1:0]};

    raw = eff_sub ? ({1'b0, sig_big} - {1'b0, sig_aln})
                  : ({1'b0, sig_big} + {1'b0, sig_aln});

    lz = 5'd0;
    for (int i = 0; i < SW; i++) begin
      if (raw[i]) lz = 5'(SW - 1 - i);
    end

    if (raw[SW]) begin
      norm   = {raw[SW:2], raw[1] | raw[0]};
      e_norm = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      norm   = raw[SW-1:0] << lz;
      e_norm = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
    end

    rnd_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_rnd = {1'b0, norm[SW-1:3]} + {24'b0, rnd_up};
    e_fin    = e_norm + (mant_rnd[24] ? 10'sd1 : 10'sd0);

    if (raw == '0) begin
      finite_sum = 32'h0000_0000;
    end else if (e_norm <= 10'sd0) begin
      finite_sum = {s_big, 31'b0};
    end else if (e_fin >= EXP_LIM) begin
      finite_sum = {s_big, 8'hFF, 23'b0};
    end else begin
      finite_sum = {s_big, e_fin[7:0],
                    mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0]};
    end
  end

  // Special-operand priority: NaN, Inf, zeros, then the finite path.
  always_comb begin
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      sum = QNAN;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (a_zero && b_zero) begin
      sum = {sa & sb, 31'b0};
    end else if (a_zero) begin
      sum = b;
    end else if (b_zero) begin
      sum = a;
    end else begin
      sum = finite_sum;
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Streaming FP32 vector accumulator: sums in_data elements until in_last,
// then pulses acc_valid with the sum and element count.
//
// Handshake: in_valid qualifies in_data/in_last every cycle; there is no
// ready, the block accepts every valid beat. acc_valid is a one-cycle pulse
// with no backpressure; acc_result/acc_count hold until the next pulse.
module fp_accum
  import fp_accum_pkg::*;
#(
  parameter int DATA_WIDTH = fp_accum_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] acc_result,
  output logic                  acc_valid,
  output logic [15:0]           acc_count,
  output logic                  busy,
  output logic                  dbg_state
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $fatal(1, "fp_accum: DATA_WIDTH must be 32");
  end

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   acc, acc_nxt, add_sum, load_val;
  logic [15:0]             cnt, cnt_nxt;

  fp_add_comb u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: open on a non-last beat, close on a last beat.
  always_comb begin
    state_nxt = state;
    if (in_valid) state_nxt = in_last ? ST_IDLE : ST_RUN;
  end

  // FSM outputs.
  always_comb begin
    busy      = (state == ST_RUN);
    dbg_state = state;
  end

  // Next accumulator/count: load on the first element, add afterwards.
  always_comb begin
    load_val = fp_load(in_data);
    if (state == ST_IDLE) begin
      acc_nxt = load_val;
      cnt_nxt = 16'd1;
    end else begin
      acc_nxt = add_sum;
      cnt_nxt = (cnt == COUNT_MAX) ? COUNT_MAX : cnt + 16'd1;
    end
  end

  // Accumulator datapath and result capture on the closing element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      acc_result <= '0;
      acc_count  <= '0;
      acc_valid  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (in_valid) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (in_last) begin
          acc_result <= acc_nxt;
          acc_count  <= cnt_nxt;
          acc_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum: hand-computed FP32 sums, special values,
// back-to-back vectors and reset in mid-vector.
module tb_fp_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] acc_result;
  logic        acc_valid;
  logic [15:0] acc_count;
  logic        busy;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  fp_accum dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .acc_result (acc_result),
    .acc_valid  (acc_valid),
    .acc_count  (acc_count),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one element at the falling edge; sampled on the next rising edge.
  task automatic drive(input logic [31:0] d, input logic l);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (acc_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", acc_result, 32'h0); end
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", acc_valid); end
    n_checks++; if (acc_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", acc_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sum3();
    drive(32'h3F80_0000, 1'b0);
    drive(32'h4000_0000, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sum3_busy: got %b expected 1", busy); end
    n_checks++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL sum3_state: got %b expected 1", dbg_state); end
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL sum3_early_valid: got %b expected 0", acc_valid); end
    drive(32'h4040_0000, 1'b1);
    drive_idle();
    n_checks++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL sum3_valid: got %b expected 1", acc_valid); end
    n_checks++; if (acc_result !== 32'h40C0_0000) begin n_fail++; $display("FAIL sum3_result: got %h expected %h", acc_result, 32'h40C0_0000); end
    n_checks++; if (acc_count !== 16'd3) begin n_fail++; $display("FAIL sum3_count: got %0d expected 3", acc_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sum3_busy_after: got %b expected 0", busy); end
    drive_idle();
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL sum3_pulse_width: got %b expected 0", acc_valid); end
    n_checks++; if (acc_result !== 32'h40C0_0000) begin n_fail++; $display("FAIL sum3_hold_result: got %h expected %h", acc_result, 32'h40C0_0000); end
    n_checks++; if (acc_count !== 16'd3) begin n_fail++; $display("FAIL sum3_hold_count: got %0d expected 3", acc_count); end
  endtask

  task automatic test_pairs();
    logic [31:0] pa [16];
    logic [31:0] pb [16];
    logic [31:0] pe [16];
    pa = '{32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F7FFFFF,
           32'h40000000, 32'h80000000, 32'h7F800000, 32'h7F800001,
           32'h3F800000, 32'h00800000, 32'h3F800000, 32'hFF800000,
           32'h3FC00000, 32'h3F800001, 32'hBF800000, 32'h00000000};
    pb = '{32'h33800000, 32'h33800001, 32'hFF800000, 32'h7F7FFFFF,
           32'hC0000000, 32'h80000000, 32'h3F800000, 32'h3F800000,
           32'hBF400000, 32'h80800001, 32'h00000005, 32'h7F7FFFFF,
           32'h3FC00000, 32'h33800000, 32'h80000000, 32'h80000000};
    pe = '{32'h3F800000, 32'h3F800001, 32'h7FC00000, 32'h7F800000,
           32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
           32'h3E800000, 32'h80000000, 32'h3F800000, 32'hFF800000,
           32'h40400000, 32'h3F800002, 32'hBF800000, 32'h00000000};
    for (int i = 0; i < 16; i++) begin
      drive(pa[i], 1'b0);
      drive(pb[i], 1'b1);
      drive_idle();
      n_checks++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL pair%0d_valid: got %b expected 1", i, acc_valid); end
      n_checks++; if (acc_result !== pe[i]) begin n_fail++; $display("FAIL pair%0d_result: %h + %h got %h expected %h", i, pa[i], pb[i], acc_result, pe[i]); end
      n_checks++; if (acc_count !== 16'd2) begin n_fail++; $display("FAIL pair%0d_count: got %0d expected 2", i, acc_count); end
    end
  endtask

  task automatic test_nan_sticky();
    drive(32'h7FA0_0000, 1'b0);
    drive(32'h3F80_0000, 1'b0);
    drive(32'h4000_0000, 1'b1);
    drive_idle();
    n_checks++; if (acc_result !== 32'h7FC0_0000) begin n_fail++; $display("FAIL nan_sticky_result: got %h expected %h", acc_result, 32'h7FC0_0000); end
    n_checks++; if (acc_count !== 16'd3) begin n_fail++; $display("FAIL nan_sticky_count: got %0d expected 3", acc_count); end
  endtask

  task automatic test_single();
    drive(32'h0000_0001, 1'b1);
    drive_idle();
    n_checks++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL single_denorm_valid: got %b expected 1", acc_valid); end
    n_checks++; if (acc_result !== 32'h0000_0000) begin n_fail++; $display("FAIL single_denorm_result: got %h expected %h", acc_result, 32'h0); end
    n_checks++; if (acc_count !== 16'd1) begin n_fail++; $display("FAIL single_denorm_count: got %0d expected 1", acc_count); end
    drive(32'h8000_0003, 1'b1);
    drive_idle();
    n_checks++; if (acc_result !== 32'h8000_0000) begin n_fail++; $display("FAIL single_negdenorm_result: got %h expected %h", acc_result, 32'h8000_0000); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    drive(32'h3F80_0000, 1'b0);
    drive(32'h4000_0000, 1'b1);
    drive(32'h4080_0000, 1'b1);
    n_checks++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b expected 1", acc_valid); end
    n_checks++; if (acc_result !== 32'h4040_0000) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", acc_result, 32'h4040_0000); end
    n_checks++; if (acc_count !== 16'd2) begin n_fail++; $display("FAIL b2b_first_count: got %0d expected 2", acc_count); end
    drive_idle();
    n_checks++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b expected 1", acc_valid); end
    n_checks++; if (acc_result !== 32'h4080_0000) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", acc_result, 32'h4080_0000); end
    n_checks++; if (acc_count !== 16'd1) begin n_fail++; $display("FAIL b2b_second_count: got %0d expected 1", acc_count); end
    drive_idle();
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_valid: got %b expected 0", acc_valid); end
  endtask

  task automatic test_reset_mid();
    drive(32'h3F80_0000, 1'b0);
    drive(32'h4000_0000, 1'b0);
    drive_idle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", acc_valid); end
    n_checks++; if (acc_result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected %h", acc_result, 32'h0); end
    n_checks++; if (acc_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", acc_count); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pulse%0d: got %b expected 0", i, acc_valid); end
    end
    drive(32'h40A0_0000, 1'b1);
    drive_idle();
    n_checks++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid: got %b expected 1", acc_valid); end
    n_checks++; if (acc_result !== 32'h40A0_0000) begin n_fail++; $display("FAIL rstmid_next_result: got %h expected %h", acc_result, 32'h40A0_0000); end
    n_checks++; if (acc_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected 1", acc_count); end
  endtask

  initial begin
    test_reset();
    test_sum3();
    test_pairs();
    test_nan_sticky();
    test_single();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_accum.md
FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 taken from package parameters, meaning the IEEE-754 word width; elaboration SHALL be fatal if DATA_WIDTH != 32.
REQ-002 SHALL have port clk  input  1  clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_data  input  DATA_WIDTH  FP32 product from fp_mul.result.
REQ-005 SHALL have port in_valid  input  1  in_data valid this cycle; driven by fp_mul.result_valid.
REQ-006 SHALL have port in_last  input  1  marks the final element of the current vector; qualified by in_valid.
REQ-007 SHALL have port acc_result  output  DATA_WIDTH  FP32 sum of the completed vector.
REQ-008 SHALL have port acc_valid  output  1  single-cycle pulse, acc_result and acc_count valid.
REQ-009 SHALL have port acc_count  output  16  number of elements summed into acc_result.
REQ-010 SHALL have port busy  output  1  high while a vector is open (state RUN).

Function
REQ-011 SHALL always accept input; there is no backpressure, and in_valid with no open vector opens one.
REQ-012 SHALL implement FSM states IDLE and RUN; IDLE->RUN on in_valid && !in_last; RUN->IDLE on in_valid && in_last; all other cases hold the state.
REQ-013 SHALL load the first element of a vector as the accumulator and add each later element into the accumulator in the cycle it arrives (loop latency 1 cycle).
REQ-014 SHALL assert acc_valid exactly one cycle after the in_last element is accepted, with acc_result = the final sum including that element.
REQ-015 SHALL treat in_valid && in_last in IDLE as a one-element vector: acc_result = in_data (after FTZ), acc_count = 1.
REQ-016 SHALL start a new vector from element n+1 when that element arrives in the cycle directly after in_last; no bubble is required.
REQ-017 SHALL add with round-to-nearest-ties-to-even using guard, round and sticky bits over the aligned 24-bit significands plus 3 extra bits.
REQ-018 SHALL flush denormal inputs to zero with sign preserved, and flush underflowing results to zero with the sign of the result.
REQ-019 SHALL return canonical NaN 0x7FC00000 for any NaN operand and for +Inf + -Inf; Inf + finite SHALL equal that Inf; once NaN, the accumulator SHALL stay NaN until the vector closes.
REQ-020 SHALL return signed Inf (exp 0xFF, mantissa 0) when the rounded exponent is >= 255.
REQ-021 SHALL return +0 for an exact cancellation x + (-x); (-0) + (-0) SHALL return -0.
REQ-022 SHALL count elements per vector, saturating at 65535; the accumulator SHALL keep summing past saturation.
REQ-023 SHALL hold acc_result and acc_count between acc_valid pulses.

Reset
REQ-024 SHALL, on rst, set state IDLE, accumulator 0, count 0, acc_result 0x00000000, acc_valid 0, acc_count 0, busy 0.
REQ-025 SHALL discard a partially accumulated vector when rst is asserted mid-vector and SHALL NOT emit acc_valid for it.

Structure
REQ-026 SHALL take DATA_WIDTH from package parameters and add to it the FP32 constants EXP_WIDTH=8, MANT_WIDTH=23, BIAS=127, QNAN=0x7FC00000, plus the FSM state enum type.
REQ-027 SHALL place the combinational FP32 adder in one sub-module, fp_add_comb (inputs a, b; output sum), so that it can be reused by later pipelined adder work.

Verification
REQ-028 SHALL cover: 0x3F800000, 0x40000000, 0x40400000 (last) on consecutive cycles -> acc_result 0x40C00000, acc_count 3, acc_valid one cycle after last.
REQ-029 SHALL cover: 0x3F800000 + 0x33800000 (last) -> 0x3F800000 (tie to even); 0x3F800000 + 0x33800001 -> 0x3F800001.
REQ-030 SHALL cover: 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
REQ-031 SHALL cover: single element 0x00000001 with in_last -> acc_result 0x00000000, acc_count 1; 0x40000000 + 0xC0000000 -> 0x00000000.
REQ-032 SHALL cover: two vectors back-to-back with no gap (1.0, 2.0 last; then 4.0 last) -> 0x40400000 then 0x40800000, each with its own acc_valid pulse.
REQ-033 SHALL cover: rst asserted after two elements of an open vector -> no acc_valid and busy=0; the next vector 5.0 (last) -> 0x40A00000, acc_count 1.
